// File: rtl/password_lock_ctrl.sv
// Keypad password lock: INPUT/OPEN/SETPWD/ALARM controller with relock and alarm timers.
// Latency 1 (all outputs registered); no backpressure, key pulses are consumed or dropped.
module password_lock_ctrl #(
    parameter int unsigned PWD_LEN      = 4,
    parameter logic [15:0] DEFAULT_PWD  = 16'h1234,
    parameter int unsigned MAX_FAIL     = 3,
    parameter logic [31:0] OPEN_CYCLES  = 32'd250_000_000,
    parameter logic [31:0] ALARM_CYCLES = 32'd500_000_000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] key_trigger,
    output logic [1:0]  state,
    output logic        unlocked,
    output logic        alarm,
    output logic [15:0] entry,
    output logic [2:0]  digit_cnt,
    output logic [1:0]  fail_cnt,
    output logic        pwd_updated
);

    typedef enum logic [1:0] {
        ST_INPUT  = 2'd0,
        ST_OPEN   = 2'd1,
        ST_SETPWD = 2'd2,
        ST_ALARM  = 2'd3
    } state_e;

    // Timer holds "cycles left after this one", so expiry fires exactly N cycles after entry.
    localparam logic [31:0] OPEN_LOAD  = (OPEN_CYCLES  == 32'd0) ? 32'd0 : OPEN_CYCLES  - 32'd1;
    localparam logic [31:0] ALARM_LOAD = (ALARM_CYCLES == 32'd0) ? 32'd0 : ALARM_CYCLES - 32'd1;
    localparam logic [2:0]  FULL_CNT   = 3'(PWD_LEN);
    localparam logic [2:0]  FAIL_LIMIT = 3'(MAX_FAIL);

    state_e      state_q, state_d;
    logic [15:0] pwd_q, pwd_d;
    logic [15:0] entry_q, entry_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  fail_q, fail_d;
    logic [31:0] timer_q, timer_d;
    logic        upd_q, upd_d;
    logic        unlocked_q, alarm_q;

    logic        key_vld;
    logic        is_digit, is_enter, is_clear, is_set;
    logic [3:0]  digit;
    logic        expired;
    logic        full;
    logic [2:0]  fail_inc;
    logic        unused_keys;

    assign unused_keys = ^key_trigger[15:13];

    always_comb begin
        key_vld  = $onehot(key_trigger[12:0]);
        is_digit = key_vld && (|key_trigger[9:0]);
        is_enter = key_vld && key_trigger[10];
        is_clear = key_vld && key_trigger[11];
        is_set   = key_vld && key_trigger[12];
        digit    = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (key_trigger[i]) digit = 4'(i);
        end
    end

    assign expired  = (timer_q == 32'd0);
    assign full     = (cnt_q == FULL_CNT);
    assign fail_inc = {1'b0, fail_q} + 3'd1;

    always_comb begin
        state_d = state_q;
        pwd_d   = pwd_q;
        entry_d = entry_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        upd_d   = 1'b0;
        timer_d = expired ? 32'd0 : timer_q - 32'd1;

        case (state_q)
            ST_INPUT: begin
                if (is_digit) begin
                    if (!full) begin
                        entry_d = {entry_q[11:0], digit};
                        cnt_d   = cnt_q + 3'd1;
                    end
                end else if (is_clear) begin
                    entry_d = 16'd0;
                    cnt_d   = 3'd0;
                end else if (is_enter) begin
                    entry_d = 16'd0;
                    cnt_d   = 3'd0;
                    if (full && entry_q == pwd_q) begin
                        state_d = ST_OPEN;
                        fail_d  = 2'd0;
                        timer_d = OPEN_LOAD;
                    end else if (fail_inc == FAIL_LIMIT) begin
                        state_d = ST_ALARM;
                        fail_d  = 2'(MAX_FAIL);
                        timer_d = ALARM_LOAD;
                    end else begin
                        fail_d  = fail_inc[1:0];
                    end
                end
            end

            ST_OPEN: begin
                if (expired || is_enter || is_clear) begin
                    state_d = ST_INPUT;
                    entry_d = 16'd0;
                    cnt_d   = 3'd0;
                    timer_d = 32'd0;
                end else if (is_set) begin
                    state_d = ST_SETPWD;
                    entry_d = 16'd0;
                    cnt_d   = 3'd0;
                    timer_d = OPEN_LOAD;
                end
            end

            ST_SETPWD: begin
                // Timeout beats any key and abandons the half-typed new password.
                if (expired) begin
                    state_d = ST_INPUT;
                    entry_d = 16'd0;
                    cnt_d   = 3'd0;
                    timer_d = 32'd0;
                end else if (is_digit) begin
                    if (!full) begin
                        entry_d = {entry_q[11:0], digit};
                        cnt_d   = cnt_q + 3'd1;
                    end
                end else if (is_clear) begin
                    entry_d = 16'd0;
                    cnt_d   = 3'd0;
                end else if (is_enter) begin
                    entry_d = 16'd0;
                    cnt_d   = 3'd0;
                    if (full) begin
                        pwd_d   = entry_q;
                        upd_d   = 1'b1;
                        state_d = ST_INPUT;
                        timer_d = 32'd0;
                    end
                end
            end

            ST_ALARM: begin
                if (expired) begin
                    state_d = ST_INPUT;
                    fail_d  = 2'd0;
                    entry_d = 16'd0;
                    cnt_d   = 3'd0;
                    timer_d = 32'd0;
                end
            end

            default: begin
                state_d = ST_INPUT;
                entry_d = 16'd0;
                cnt_d   = 3'd0;
                timer_d = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_INPUT;
            pwd_q      <= DEFAULT_PWD;
            entry_q    <= 16'd0;
            cnt_q      <= 3'd0;
            fail_q     <= 2'd0;
            timer_q    <= 32'd0;
            upd_q      <= 1'b0;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pwd_q      <= pwd_d;
            entry_q    <= entry_d;
            cnt_q      <= cnt_d;
            fail_q     <= fail_d;
            timer_q    <= timer_d;
            upd_q      <= upd_d;
            unlocked_q <= (state_d == ST_OPEN) || (state_d == ST_SETPWD);
            alarm_q    <= (state_d == ST_ALARM);
        end
    end

    assign state       = state_q;
    assign unlocked    = unlocked_q;
    assign alarm       = alarm_q;
    assign entry       = entry_q;
    assign digit_cnt   = cnt_q;
    assign fail_cnt    = fail_q;
    assign pwd_updated = upd_q;

endmodule

// File: tb/tb_password_lock_ctrl.sv
// Bench for password_lock_ctrl: directed scenarios with literal expectations plus
// randomized keys, all cross-checked every cycle against a behavioural model.
module tb_password_lock_ctrl;

    localparam int OPEN_N  = 20;
    localparam int ALARM_N = 50;
    localparam int MAXF    = 3;
    localparam logic [15:0] K_ENTER = 16'h0400;
    localparam logic [15:0] K_CLEAR = 16'h0800;
    localparam logic [15:0] K_SET   = 16'h1000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] key_trigger = 16'h0;
    logic [1:0]  state;
    logic        unlocked;
    logic        alarm;
    logic [15:0] entry;
    logic [2:0]  digit_cnt;
    logic [1:0]  fail_cnt;
    logic        pwd_updated;

    password_lock_ctrl #(
        .PWD_LEN      (4),
        .DEFAULT_PWD  (16'h1234),
        .MAX_FAIL     (MAXF),
        .OPEN_CYCLES  (32'd20),
        .ALARM_CYCLES (32'd50)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .key_trigger (key_trigger),
        .state       (state),
        .unlocked    (unlocked),
        .alarm       (alarm),
        .entry       (entry),
        .digit_cnt   (digit_cnt),
        .fail_cnt    (fail_cnt),
        .pwd_updated (pwd_updated)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: state as an integer, timed states exit by elapsed-cycle arithmetic.
    int          m_st = 0;
    int          m_cnt = 0;
    int          m_fail = 0;
    int          cyc = 0;
    int          t_enter = 0;
    logic [15:0] m_pwd = 16'h1234;
    logic [15:0] m_entry = 16'h0;
    bit          m_upd = 1'b0;
    bit          started = 1'b0;
    int          ones;
    int          kidx;

    task automatic go_state(input int s);
        m_st    = s;
        t_enter = cyc;
        m_entry = 16'h0;
        m_cnt   = 0;
    endtask

    task automatic push_digit();
        if (m_cnt < 4) begin
            m_entry = {m_entry[11:0], 4'(kidx)};
            m_cnt++;
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        started = 1'b1;
        m_upd = 1'b0;
        if (!rstn) begin
            m_st = 0; m_pwd = 16'h1234; m_entry = 16'h0; m_cnt = 0; m_fail = 0; t_enter = cyc;
        end else begin
            ones = $countones(key_trigger[12:0]);
            kidx = -1;
            if (ones == 1)
                for (int i = 0; i < 13; i++) if (key_trigger[i]) kidx = i;
            case (m_st)
                0: begin
                    if (kidx >= 0 && kidx <= 9) push_digit();
                    else if (kidx == 11) begin m_entry = 16'h0; m_cnt = 0; end
                    else if (kidx == 10) begin
                        if (m_cnt == 4 && m_entry == m_pwd) begin m_fail = 0; go_state(1); end
                        else if (m_fail + 1 == MAXF) begin m_fail = MAXF; go_state(3); end
                        else begin m_fail++; m_entry = 16'h0; m_cnt = 0; end
                    end
                end
                1: begin
                    if (cyc - t_enter >= OPEN_N) go_state(0);
                    else if (kidx == 10 || kidx == 11) go_state(0);
                    else if (kidx == 12) go_state(2);
                end
                2: begin
                    if (cyc - t_enter >= OPEN_N) go_state(0);
                    else if (kidx >= 0 && kidx <= 9) push_digit();
                    else if (kidx == 11) begin m_entry = 16'h0; m_cnt = 0; end
                    else if (kidx == 10) begin
                        if (m_cnt == 4) begin m_pwd = m_entry; m_upd = 1'b1; go_state(0); end
                        else begin m_entry = 16'h0; m_cnt = 0; end
                    end
                end
                default: begin
                    if (cyc - t_enter >= ALARM_N) begin m_fail = 0; go_state(0); end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("outputs_vs_model",
                  {6'd0, state, unlocked, alarm, entry, digit_cnt, fail_cnt, pwd_updated},
                  {6'd0, 2'(m_st), (m_st == 1 || m_st == 2), (m_st == 3), m_entry,
                   3'(m_cnt), 2'(m_fail), m_upd});
        end
    end

    // Called at a negedge; the key covers exactly one rising edge.
    task automatic press(input logic [15:0] k);
        key_trigger = k;
        @(negedge clk);
        key_trigger = 16'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic enter_code(input logic [15:0] code);
        for (int i = 0; i < 4; i++) press(16'h1 << code[15-4*i -: 4]);
        press(K_ENTER);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_unlocked"}, 32'(unlocked), 32'd0);
        check({tag, "_alarm"}, 32'(alarm), 32'd0);
        check({tag, "_entry"}, 32'(entry), 32'd0);
        check({tag, "_digit_cnt"}, 32'(digit_cnt), 32'd0);
        check({tag, "_fail_cnt"}, 32'(fail_cnt), 32'd0);
        check({tag, "_pwd_updated"}, 32'(pwd_updated), 32'd0);
    endtask

    int n;
    int r;
    logic [15:0] p;

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rstn = 1'b1;
        idle(1);

        // Correct default code opens, relocks after exactly 20 cycles.
        enter_code(16'h1234);
        check("open_state", 32'(state), 32'd1);
        check("open_unlocked", 32'(unlocked), 32'd1);
        check("open_fail", 32'(fail_cnt), 32'd0);
        n = 0;
        while (state == 2'd1 && n < 100) begin idle(1); n++; end
        check("open_duration", 32'(n), 32'd20);

        // Multi-bit key ignored, fifth digit ignored, CLEAR empties.
        press(16'h0003);
        check("multikey_entry", 32'(entry), 32'd0);
        check("multikey_cnt", 32'(digit_cnt), 32'd0);
        press(16'h0002); press(16'h0004); press(16'h0008); press(16'h0010); press(16'h0200);
        check("five_digits_entry", 32'(entry), 32'h1234);
        check("five_digits_cnt", 32'(digit_cnt), 32'd4);
        press(K_CLEAR);
        check("clear_entry", 32'(entry), 32'd0);
        check("clear_cnt", 32'(digit_cnt), 32'd0);

        // Three wrong codes trip the alarm; alarm ignores keys for 50 cycles.
        enter_code(16'h1111);
        check("wrong1_fail", 32'(fail_cnt), 32'd1);
        enter_code(16'h1111);
        check("wrong2_fail", 32'(fail_cnt), 32'd2);
        enter_code(16'h1111);
        check("alarm_state", 32'(state), 32'd3);
        check("alarm_flag", 32'(alarm), 32'd1);
        check("alarm_fail", 32'(fail_cnt), 32'd3);
        n = 0;
        while (state == 2'd3 && n < 200) begin
            press(16'h1 << $urandom_range(0, 12));
            n++;
        end
        check("alarm_duration", 32'(n), 32'd50);
        check("alarm_exit_fail", 32'(fail_cnt), 32'd0);

        // Key arriving on the exact expiry cycle is dropped.
        enter_code(16'h1234);
        idle(OPEN_N - 1);
        press(K_ENTER);
        check("expiry_enter_state", 32'(state), 32'd0);
        check("expiry_enter_fail", 32'(fail_cnt), 32'd0);
        enter_code(16'h1234);
        idle(OPEN_N - 1);
        press(K_SET);
        check("expiry_set_state", 32'(state), 32'd0);

        // Change password to 5678.
        enter_code(16'h1234);
        press(K_SET);
        check("setpwd_state", 32'(state), 32'd2);
        enter_code(16'h5678);
        check("setpwd_upd", 32'(pwd_updated), 32'd1);
        check("setpwd_exit_state", 32'(state), 32'd0);
        idle(1);
        check("setpwd_upd_pulse", 32'(pwd_updated), 32'd0);
        enter_code(16'h1234);
        check("old_pwd_fail", 32'(fail_cnt), 32'd1);
        enter_code(16'h5678);
        check("new_pwd_state", 32'(state), 32'd1);
        idle(OPEN_N + 2);

        // Reset in SETPWD after new digits restores default password.
        enter_code(16'h5678);
        press(K_SET);
        press(16'h0020); press(16'h0040);
        check("pre_reset_entry", 32'(entry), 32'h0056);
        rstn = 1'b0;
        idle(1);
        check_reset_outputs("midreset");
        rstn = 1'b1;
        enter_code(16'h5678);
        check("post_reset_old_fail", 32'(fail_cnt), 32'd1);
        enter_code(16'h1234);
        check("post_reset_default_open", 32'(state), 32'd1);

        // Randomized traffic, checked against the model each cycle.
        for (int it = 0; it < 600; it++) begin
            r = $urandom_range(0, 99);
            if (r < 25) begin
                p = m_pwd;
                enter_code(p);
                if ($urandom_range(0, 1) == 1) press(K_SET);
            end else if (r < 35) press(K_SET);
            else if (r < 42) press(K_ENTER);
            else if (r < 46) press(K_CLEAR);
            else if (r < 52) press(16'($urandom) & 16'h1FFF);
            else if (r < 55) idle($urandom_range(1, 25));
            else if (r < 57) begin rstn = 1'b0; idle(1); rstn = 1'b1; end
            else press((16'h1 << $urandom_range(0, 9)) | (16'($urandom_range(0, 7)) << 13));
        end

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
